// File: rtl/crop_window_tx_pkg.sv
// Shared definitions for the crop window transmitter.
// Holds the FSM state encodings and the helper that sizes coordinate and
// window-size fields so that a full-width window (size == image dimension)
// can be represented.
package crop_window_tx_pkg;

  // FSM state encodings; the values are fixed so that legacy tooling that
  // probes the state register keeps decoding it the same way.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Number of bits needed to hold any value in 0..n (inclusive), so a
  // window width equal to the image width still fits.
  function automatic int coordWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/crop_window_tx_if.sv
// Pixel stream bundle for the crop window transmitter.
// Carries both the raster input channel and the cropped output channel.
//   in_data/in_valid   -> engine     input pixel and its valid
//   in_ready           <- engine     engine accepts the input pixel
//   out_data/out_valid <- engine     cropped pixel (registered) and its valid
//   out_last           <- engine     marks the final pixel of the window
//   out_ready          -> engine     downstream (FIFO) accepts the output pixel
// The master modport is the engine's view; slave is the surrounding logic.
interface crop_window_tx_if #(
  parameter int DATA_WIDTH = 12
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/crop_window_tx_stream_out_reg.sv
// Single-entry ready/valid output register carrying a data word and a
// last flag.
//   clk, reset  clock and synchronous active-high reset
//   load_i      capture data_i/last_i this cycle (caller guarantees room)
//   data_i      word to capture
//   last_i      last flag to capture
//   ready_i     downstream accepts the held word
//   valid_o     register holds a word
//   data_o      held word, stable while stalled
//   last_o      held last flag, stable while stalled
module crop_window_tx_stream_out_reg #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  // A load always wins over an unload, so a simultaneous hand-off and
  // refill keeps valid high and sustains one word per clock. Data and last
  // only change on a load, which keeps them stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/crop_window_tx.sv
// Streaming crop engine / transmitter.
// Accepts one raster-order frame of IMG_W x IMG_H pixels and forwards only
// the pixels inside a runtime window, honouring downstream back-pressure.
//   clk, reset  clock and synchronous active-high reset
//   start       one-cycle pulse: sample cfg_* and begin a frame (IDLE only)
//   cfg_x0/y0   window top-left corner
//   cfg_w/h     window size in pixels / rows
//   cfg_err     one-cycle pulse: start rejected because the window is bad
//   busy        high while a frame is being consumed or drained
//   done        one-cycle pulse: frame consumed and final pixel handed off
//   stream      pixel stream bundle (input and cropped output channels)
module crop_window_tx
  import crop_window_tx_pkg::*;
#(
  parameter  int DATA_WIDTH = 12,
  parameter  int IMG_W      = 20,
  parameter  int IMG_H      = 20,
  localparam int XW         = coordWidth(IMG_W),
  localparam int YW         = coordWidth(IMG_H)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [XW-1:0]          cfg_x0,
  input  logic [YW-1:0]          cfg_y0,
  input  logic [XW-1:0]          cfg_w,
  input  logic [YW-1:0]          cfg_h,
  output logic                   cfg_err,
  output logic                   busy,
  output logic                   done,
  crop_window_tx_if.master       stream
);

  localparam logic [XW:0]   IMG_W_EXT = (XW+1)'(IMG_W);
  localparam logic [YW:0]   IMG_H_EXT = (YW+1)'(IMG_H);
  localparam logic [XW-1:0] COL_MAX   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_MAX   = YW'(IMG_H - 1);

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x0_q, x0_d, w_q, w_d, col_q, col_d;
  logic [YW-1:0] y0_q, y0_d, h_q, h_d, row_q, row_d;
  logic          cfgErr_q, cfgErr_d;
  logic          done_q, done_d;

  logic [XW:0]   cfgXEnd, winXEnd, colExt;
  logic [YW:0]   cfgYEnd, winYEnd, rowExt;
  logic          cfgOk;
  logic          keep;
  logic          lastKept;
  logic          endOfFrame;
  logic          outFree;
  logic          inReady;
  logic          accept;
  logic          load;
  logic          startOk;

  // Window checks use one extra bit so that x0+w cannot wrap and a window
  // ending exactly on the image edge is still accepted.
  assign cfgXEnd = {1'b0, cfg_x0} + {1'b0, cfg_w};
  assign cfgYEnd = {1'b0, cfg_y0} + {1'b0, cfg_h};
  assign cfgOk   = (cfg_w != '0) && (cfg_h != '0) &&
                   (cfgXEnd <= IMG_W_EXT) && (cfgYEnd <= IMG_H_EXT);

  // Window membership of the pixel currently offered, against the latched
  // configuration so mid-frame cfg_* changes have no effect.
  assign winXEnd  = {1'b0, x0_q} + {1'b0, w_q};
  assign winYEnd  = {1'b0, y0_q} + {1'b0, h_q};
  assign colExt   = {1'b0, col_q};
  assign rowExt   = {1'b0, row_q};
  assign keep     = (colExt >= {1'b0, x0_q}) && (colExt < winXEnd) &&
                    (rowExt >= {1'b0, y0_q}) && (rowExt < winYEnd);
  assign lastKept = (colExt == winXEnd - 1'b1) && (rowExt == winYEnd - 1'b1);

  assign endOfFrame = (col_q == COL_MAX) && (row_q == ROW_MAX);

  // Dropped pixels never wait for the output register; kept pixels need
  // the register empty or being emptied this cycle.
  assign outFree = !stream.out_valid || stream.out_ready;
  assign inReady = (state_q == ST_RUN) && (!keep || outFree);
  assign accept  = stream.in_valid && inReady;
  assign load    = accept && keep;
  assign startOk = (state_q == ST_IDLE) && start && cfgOk;

  // Frame sequencing: IDLE waits for a valid start, RUN consumes the frame,
  // DRAIN waits for the output register to hand off its final pixel.
  always_comb begin
    state_d  = state_q;
    cfgErr_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfgOk) state_d = ST_RUN;
          else       cfgErr_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept && endOfFrame) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outFree) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow configuration and raster position; the counters restart on a
  // frame start and advance once per accepted pixel, wrapping per row.
  always_comb begin
    x0_d  = x0_q;
    y0_d  = y0_q;
    w_d   = w_q;
    h_d   = h_q;
    col_d = col_q;
    row_d = row_q;
    if (startOk) begin
      x0_d  = cfg_x0;
      y0_d  = cfg_y0;
      w_d   = cfg_w;
      h_d   = cfg_h;
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = endOfFrame ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // All control state, cleared by reset so an interrupted frame is simply
  // abandoned without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      cfgErr_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      row_q    <= row_d;
      cfgErr_q <= cfgErr_d;
      done_q   <= done_d;
    end
  end

  crop_window_tx_stream_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outReg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .data_i  (stream.in_data),
    .last_i  (lastKept),
    .ready_i (stream.out_ready),
    .valid_o (stream.out_valid),
    .data_o  (stream.out_data),
    .last_o  (stream.out_last)
  );

  assign stream.in_ready = inReady;
  assign cfg_err         = cfgErr_q;
  assign done            = done_q;
  assign busy            = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_crop_window_tx.sv
// Self-checking bench for crop_window_tx.
// Two engines are instantiated: a 4x4 one for the directed frames and a
// 20x20 one for randomised windows. Stimulus is shared and steered by sel;
// outputs are muxed back so one set of tasks drives either engine.
module tb_crop_window_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        start;
  logic [4:0]  cfgX0, cfgY0, cfgW, cfgH;
  logic [11:0] inData;
  logic        inValid;
  logic        outReady;

  logic sErr, sBusy, sDone, bErr, bBusy, bDone;

  logic        obsValid, obsLast, obsInReady, obsErr, obsBusy, obsDone;
  logic [11:0] obsData;

  logic [11:0] pix [0:399];

  int nChecks = 0;
  int nFails  = 0;

  crop_window_tx_if #(.DATA_WIDTH(12)) smallIf ();
  crop_window_tx_if #(.DATA_WIDTH(12)) bigIf ();

  assign smallIf.in_data   = inData;
  assign smallIf.in_valid  = inValid && !sel;
  assign smallIf.out_ready = outReady && !sel;
  assign bigIf.in_data     = inData;
  assign bigIf.in_valid    = inValid && sel;
  assign bigIf.out_ready   = outReady && sel;

  crop_window_tx #(.DATA_WIDTH(12), .IMG_W(4), .IMG_H(4)) dutSmall (
    .clk     (clk),
    .reset   (reset),
    .start   (start && !sel),
    .cfg_x0  (cfgX0[2:0]),
    .cfg_y0  (cfgY0[2:0]),
    .cfg_w   (cfgW[2:0]),
    .cfg_h   (cfgH[2:0]),
    .cfg_err (sErr),
    .busy    (sBusy),
    .done    (sDone),
    .stream  (smallIf)
  );

  crop_window_tx #(.DATA_WIDTH(12), .IMG_W(20), .IMG_H(20)) dutBig (
    .clk     (clk),
    .reset   (reset),
    .start   (start && sel),
    .cfg_x0  (cfgX0),
    .cfg_y0  (cfgY0),
    .cfg_w   (cfgW),
    .cfg_h   (cfgH),
    .cfg_err (bErr),
    .busy    (bBusy),
    .done    (bDone),
    .stream  (bigIf)
  );

  assign obsValid   = sel ? bigIf.out_valid : smallIf.out_valid;
  assign obsLast    = sel ? bigIf.out_last  : smallIf.out_last;
  assign obsData    = sel ? bigIf.out_data  : smallIf.out_data;
  assign obsInReady = sel ? bigIf.in_ready  : smallIf.in_ready;
  assign obsErr     = sel ? bErr  : sErr;
  assign obsBusy    = sel ? bBusy : sBusy;
  assign obsDone    = sel ? bDone : sDone;

  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start with the given window; called at posedge+1, returns at
  // posedge+1 just after the start edge.
  task automatic pulseStart(input int x0, input int y0, input int w, input int h);
    cfgX0 = 5'(x0);
    cfgY0 = 5'(y0);
    cfgW  = 5'(w);
    cfgH  = 5'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // A rejected start: error pulse for exactly one cycle, engine stays idle.
  task automatic applyBadConfig(input string tag, input int x0, input int y0, input int w, input int h);
    pulseStart(x0, y0, w, h);
    checkOutput({tag, " cfg_err pulse"}, 32'(obsErr), 1);
    checkOutput({tag, " idle busy"}, 32'(obsBusy), 0);
    checkOutput({tag, " idle in_ready"}, 32'(obsInReady), 0);
    @(posedge clk); #1;
    checkOutput({tag, " cfg_err clears"}, 32'(obsErr), 0);
    checkOutput({tag, " still idle"}, 32'(obsBusy), 0);
  endtask

  // Run one complete frame and compare against the reference crop built
  // from the window rules. readyMode: 0 always ready, 1 toggling 1010,
  // 2 random, 3 held low until the whole frame has been offered.
  task automatic applyStimulus(input string tag, input int imgW, input int imgH,
                               input int x0, input int y0, input int w, input int h,
                               input int validPct, input int readyMode);
    logic [11:0] expQ[$];
    logic [11:0] prevData;
    logic        prevLast, prevStall;
    int total, inIdx, beats, sample, lastIn, lastOut, doneAt, busyErr, inStalls, holdCnt;

    expQ.delete();
    for (int r = 0; r < imgH; r++)
      for (int c = 0; c < imgW; c++)
        if (c >= x0 && c < x0 + w && r >= y0 && r < y0 + h)
          expQ.push_back(pix[r*imgW + c]);
    total = imgW * imgH;

    pulseStart(x0, y0, w, h);
    checkOutput({tag, " busy after start"}, 32'(obsBusy), 1);
    checkOutput({tag, " no cfg_err"}, 32'(obsErr), 0);

    inIdx = 0; beats = 0; sample = 0; lastIn = -1; lastOut = -1; doneAt = -1;
    busyErr = 0; inStalls = 0; holdCnt = 0; prevStall = 1'b0;
    prevData = '0; prevLast = 1'b0;
    while (doneAt < 0 && sample < 6000) begin
      inValid = (inIdx < total) && ($urandom_range(1, 100) <= validPct);
      inData  = (inIdx < total) ? pix[inIdx] : 12'h000;
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = (sample % 2 == 0);
        2:       outReady = 1'($urandom_range(0, 1));
        default: outReady = (inIdx >= total) && (holdCnt > 3);
      endcase
      @(negedge clk);
      if (prevStall)
        checkOutput($sformatf("%s hold while stalled s%0d", tag, sample),
                    {19'd0, obsValid, obsLast, obsData}, {19'd0, 1'b1, prevLast, prevData});
      if (obsDone) doneAt = sample;
      else if (!obsBusy) busyErr++;
      if (inValid && !obsInReady) inStalls++;
      if (inValid && obsInReady) begin
        inIdx++;
        lastIn = sample;
      end
      if (obsValid && outReady) begin
        if (beats < expQ.size()) begin
          checkOutput($sformatf("%s data beat %0d", tag, beats), 32'(obsData), 32'(expQ[beats]));
          checkOutput($sformatf("%s last beat %0d", tag, beats), 32'(obsLast),
                      32'(beats == expQ.size() - 1));
        end else begin
          checkOutput($sformatf("%s extra beat %0d", tag, beats), 32'(obsData), 32'hFFFF_FFFF);
        end
        beats++;
        lastOut = sample;
      end
      prevStall = obsValid && !outReady;
      prevData  = obsData;
      prevLast  = obsLast;
      if (inIdx >= total) holdCnt++;
      sample++;
      @(posedge clk); #1;
    end
    inValid  = 1'b0;
    outReady = 1'b0;

    if (doneAt < 0) begin
      checkOutput({tag, " done within budget"}, 0, 1);
    end else begin
      // done follows the later of "frame consumed" and "final beat gone"
      checkOutput({tag, " done timing"}, 32'(doneAt),
                  32'(((lastIn + 1 > lastOut) ? lastIn + 1 : lastOut) + 1));
      checkOutput({tag, " beat count"}, 32'(beats), 32'(expQ.size()));
      checkOutput({tag, " busy during frame"}, 32'(busyErr), 0);
      if (readyMode == 3)
        checkOutput({tag, " input never stalled"}, 32'(inStalls), 0);
      checkOutput({tag, " done is one cycle"}, 32'(obsDone), 0);
    end
  endtask

  // Directed 4x4 frames, reset recovery, then randomised 20x20 windows.
  initial begin
    int accepted, rx0, ry0, rw, rh;
    sel = 1'b0; start = 1'b0; inData = '0; inValid = 1'b0; outReady = 1'b0;
    cfgX0 = '0; cfgY0 = '0; cfgW = '0; cfgH = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(obsValid), 0);
    checkOutput("reset out_data", 32'(obsData), 0);
    checkOutput("reset out_last", 32'(obsLast), 0);
    checkOutput("reset busy", 32'(obsBusy), 0);
    checkOutput("reset done", 32'(obsDone), 0);
    checkOutput("reset cfg_err", 32'(obsErr), 0);
    checkOutput("reset in_ready", 32'(obsInReady), 0);
    sel = 1'b1;
    #1;
    checkOutput("reset big out_valid", 32'(obsValid), 0);
    checkOutput("reset big busy", 32'(obsBusy), 0);
    sel = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) pix[i] = 12'(i);
    $display("[TB] directed 4x4 frames");
    applyStimulus("T1", 4, 4, 1, 1, 2, 2, 100, 0);
    applyStimulus("T2", 4, 4, 0, 0, 4, 4, 100, 1);
    applyBadConfig("T3 x0+w", 3, 0, 2, 1);
    applyBadConfig("T3 w0", 0, 0, 0, 2);
    applyBadConfig("T3 y0+h", 0, 2, 1, 3);
    applyStimulus("T3 edge", 4, 4, 2, 3, 2, 1, 80, 2);
    applyStimulus("T4", 4, 4, 3, 3, 1, 1, 100, 3);

    $display("[TB] reset mid-frame");
    pulseStart(1, 1, 2, 2);
    inValid = 1'b1; outReady = 1'b1; accepted = 0;
    for (int k = 0; k < 20 && accepted < 6; k++) begin
      inData = pix[accepted];
      @(negedge clk);
      if (obsInReady) accepted++;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    checkOutput("T5 six beats accepted", 32'(accepted), 6);
    checkOutput("T5 pixel 5 held", {19'd0, obsValid, obsData}, {19'd0, 1'b1, 12'd5});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("T5 out_valid", 32'(obsValid), 0);
    checkOutput("T5 out_data", 32'(obsData), 0);
    checkOutput("T5 out_last", 32'(obsLast), 0);
    checkOutput("T5 busy", 32'(obsBusy), 0);
    checkOutput("T5 in_ready", 32'(obsInReady), 0);
    checkOutput("T5 cfg_err", 32'(obsErr), 0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("T5 no done %0d", k), {30'd0, obsDone, obsBusy}, 0);
      @(posedge clk); #1;
    end
    applyStimulus("T5 restart", 4, 4, 1, 1, 2, 2, 100, 0);

    $display("[TB] random 20x20 windows");
    sel = 1'b1;
    @(posedge clk); #1;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 400; i++) pix[i] = 12'($urandom);
      rx0 = $urandom_range(0, 19);
      ry0 = $urandom_range(0, 19);
      rw  = $urandom_range(1, 20 - rx0);
      rh  = $urandom_range(1, 20 - ry0);
      applyStimulus($sformatf("T6 f%0d", f), 20, 20, rx0, ry0, rw, rh, 70, 2);
    end
    applyStimulus("T6 full", 20, 20, 0, 0, 20, 20, 90, 2);
    applyBadConfig("T6 x0+w", 19, 0, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
